tt_um_hoene_protocol_frame_ctrl: RTL



---
 rtl/tt_um_hoene_protocol_frame_ctrl_pkg.sv | 24 ++
 rtl/tt_um_hoene_strobe_detect.sv | 24 ++
 rtl/tt_um_hoene_protocol_frame_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/tt_um_hoene_protocol_frame_ctrl_pkg.sv
// Purpose: shared encodings and sizes for the LED frame protocol blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tt_um_hoene_protocol_frame_ctrl_pkg;

    // Default colour word width; one frame carries red, green and blue words.
    localparam int CHANNEL_BITS_DEF = 10;
    localparam int FRAME_BITS_DEF   = 3 * CHANNEL_BITS_DEF;

    // FORWARD sits beside the four core states so it never aliases COMMIT.
    typedef enum logic [2:0] {
        WAIT_SYNC = 3'd0,
        RECV      = 3'd1,
        CHECK     = 3'd2,
        COMMIT    = 3'd3,
        FORWARD   = 3'd4
    } state_t;

    // Number of payload bits in one RGB frame.
    function automatic int frame_bits(input int channel_bits);
        return 3 * channel_bits;
    endfunction

endpackage

// File: rtl/tt_um_hoene_strobe_detect.sv
// Purpose: rising-edge detector on the decoder bit clock.
// Latency: strobe is combinational in the cycle in_clk first reads high.
// Backpressure: none; one strobe per in_clk rising edge.
module tt_um_hoene_strobe_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic in_clk,
    output logic strobe
);

    logic in_clk_q;

    // Remember last cycle's bit clock level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_clk_q <= 1'b0;
        end else begin
            in_clk_q <= in_clk;
        end
    end

    assign strobe = in_clk & ~in_clk_q;

endmodule

// File: rtl/tt_um_hoene_protocol_frame_ctrl.sv
// Purpose: assembles the first RGB frame after sync, then forwards later bits downstream.
// Latency: colours/frame_valid 2 cycles after the last-bit strobe (1 more with TT_UM_HOENE_FRAME_PARITY_EN); fwd_* 1 cycle.
// Backpressure: none; corrupt or truncated frames are dropped and counted in err_count.
module tt_um_hoene_protocol_frame_ctrl
    import tt_um_hoene_protocol_frame_ctrl_pkg::*;
#(
    parameter int CHANNEL_BITS = CHANNEL_BITS_DEF,
    parameter int ERRCNT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_data,
    input  logic                    in_clk,
    input  logic                    in_error,
    input  logic                    insync,
    output logic [CHANNEL_BITS-1:0] red,
    output logic [CHANNEL_BITS-1:0] green,
    output logic [CHANNEL_BITS-1:0] blue,
    output logic                    frame_valid,
    output logic                    fwd_data,
    output logic                    fwd_clk,
    output logic [ERRCNT_WIDTH-1:0] err_count
);

    localparam int FRAME_BITS = frame_bits(CHANNEL_BITS);
`ifdef TT_UM_HOENE_FRAME_PARITY_EN
    // One trailing even-parity bit follows the colour payload.
    localparam int RX_BITS = FRAME_BITS + 1;
`else
    localparam int RX_BITS = FRAME_BITS;
`endif
    localparam int CNT_W = $clog2(RX_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RX_BITS - 1);

    state_t                  state;
    logic [RX_BITS-1:0]      shift;
    logic [CNT_W-1:0]        bitcnt;
    logic                    strobe;
    logic                    abort;
    logic [FRAME_BITS-1:0]   frame;
    logic [ERRCNT_WIDTH-1:0] err_next;

    tt_um_hoene_strobe_detect u_strobe (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_clk (in_clk),
        .strobe (strobe)
    );

    assign abort    = in_error | ~insync;
    // Payload occupies the oldest bits; a parity bit, if present, is the newest.
    assign frame    = shift[RX_BITS-1 -: FRAME_BITS];
    assign err_next = (err_count == {ERRCNT_WIDTH{1'b1}}) ? err_count : err_count + 1'b1;

    // Frame sequencer: receive, optionally check, commit colours, then pass bits through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_SYNC;
            shift       <= '0;
            bitcnt      <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_valid <= 1'b0;
            fwd_data    <= 1'b0;
            fwd_clk     <= 1'b0;
            err_count   <= '0;
        end else begin
            frame_valid <= 1'b0;
            fwd_data    <= 1'b0;
            fwd_clk     <= 1'b0;
            case (state)
                WAIT_SYNC: begin
                    bitcnt <= '0;
                    if (insync && !in_error) begin
                        state <= RECV;
                    end
                end
                RECV: begin
                    // Abort wins over a simultaneous last-bit strobe.
                    if (abort) begin
                        state     <= WAIT_SYNC;
                        bitcnt    <= '0;
                        err_count <= err_next;
                    end else if (strobe) begin
                        shift  <= {shift[RX_BITS-2:0], in_data};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == LAST_IDX) begin
                            bitcnt <= '0;
`ifdef TT_UM_HOENE_FRAME_PARITY_EN
                            state  <= CHECK;
`else
                            state  <= COMMIT;
`endif
                        end
                    end
                end
                CHECK: begin
                    // Even parity: the XOR over payload plus parity bit must be zero.
                    if (abort || (^shift)) begin
                        state     <= WAIT_SYNC;
                        err_count <= err_next;
                    end else begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    red         <= frame[FRAME_BITS-1 -: CHANNEL_BITS];
                    green       <= frame[2*CHANNEL_BITS-1 -: CHANNEL_BITS];
                    blue        <= frame[CHANNEL_BITS-1:0];
                    frame_valid <= 1'b1;
                    // Forwarding opens here so a bit arriving during commit is not lost.
                    if (insync) begin
                        fwd_data <= in_data;
                        fwd_clk  <= in_clk;
                        state    <= FORWARD;
                    end else begin
                        state <= WAIT_SYNC;
                    end
                end
                FORWARD: begin
                    // Decoder errors belong to the downstream LED; only loss of sync stops us.
                    if (insync) begin
                        fwd_data <= in_data;
                        fwd_clk  <= in_clk;
                    end else begin
                        state <= WAIT_SYNC;
                    end
                end
                default: begin
                    state <= WAIT_SYNC;
                end
            endcase
        end
    end

endmodule
